// File: rtl/pack_receiver.sv
// Packet sink for a switch local port: validates address, length and payload sequence, keeps statistics.
// Optional macro RECV_STALL_EN replaces the always-ready handshake with LFSR-driven backpressure.
module pack_receiver #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned ADDR         = 0,
  parameter int unsigned MAX_PACK_LEN = 4,
  parameter int unsigned CNT_SIZE     = 16,
  parameter int unsigned DEBUG        = 0
) (
  input  logic                          clk,
  input  logic                          a_rst,
  input  logic [DATA_SIZE+ADDR_SIZE:0]  data_i,
  input  logic                          in_w,
  output logic                          out_r,
  output logic [CNT_SIZE-1:0]           pack_cnt,
  output logic [CNT_SIZE-1:0]           flit_cnt,
  output logic [CNT_SIZE-1:0]           err_cnt,
  output logic                          err_addr,
  output logic                          err_len,
  output logic                          err_seq,
  output logic                          busy
);

  localparam int unsigned FLIT_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int unsigned LEN_W     = $clog2(MAX_PACK_LEN + 2);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [DATA_SIZE-1:0]  seq_q, seq_d;
  logic [CNT_SIZE-1:0]   pack_d, flit_d, err_d;
  logic                  err_addr_d, err_len_d, err_seq_d, busy_d;

  logic                  xfer, fl_tail, addr_bad, seq_bad, len_bad, pkt_bad;
  logic [ADDR_SIZE-1:0]  fl_addr;
  logic [DATA_SIZE-1:0]  fl_data;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return (&v) ? v : v + CNT_SIZE'(1);
  endfunction

  assign fl_tail = data_i[FLIT_SIZE-1];
  assign fl_addr = data_i[FLIT_SIZE-2 -: ADDR_SIZE];
  assign fl_data = data_i[DATA_SIZE-1:0];
  assign xfer    = in_w & out_r;

  // len_q counts flits already taken in the open packet; seq_q is the payload the next flit must carry
  assign addr_bad = (fl_addr != ADDR_SIZE'(ADDR));
  assign seq_bad  = (fl_data != seq_q);
  assign len_bad  = (len_q >= LEN_W'(MAX_PACK_LEN));
  assign pkt_bad  = addr_bad | seq_bad | len_bad | (state_q == DROP);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    seq_d      = seq_q;
    pack_d     = pack_cnt;
    flit_d     = flit_cnt;
    err_d      = err_cnt;
    err_addr_d = err_addr;
    err_len_d  = err_len;
    err_seq_d  = err_seq;
    if (xfer) begin
      flit_d     = sat_inc(flit_cnt);
      err_addr_d = err_addr | addr_bad;
      err_len_d  = err_len  | len_bad;
      err_seq_d  = err_seq  | seq_bad;
      if (fl_tail) begin
        state_d = IDLE;
        len_d   = '0;
        seq_d   = '0;
        if (pkt_bad) err_d  = sat_inc(err_cnt);
        else         pack_d = sat_inc(pack_cnt);
      end else begin
        state_d = pkt_bad ? DROP : RECV;
        seq_d   = seq_q + DATA_SIZE'(1);
        // hold at MAX+1 during long drops so the width stays bounded
        if (len_q <= LEN_W'(MAX_PACK_LEN)) len_d = len_q + LEN_W'(1);
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      seq_q    <= '0;
      pack_cnt <= '0;
      flit_cnt <= '0;
      err_cnt  <= '0;
      err_addr <= 1'b0;
      err_len  <= 1'b0;
      err_seq  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      seq_q    <= seq_d;
      pack_cnt <= pack_d;
      flit_cnt <= flit_d;
      err_cnt  <= err_d;
      err_addr <= err_addr_d;
      err_len  <= err_len_d;
      err_seq  <= err_seq_d;
      busy     <= busy_d;
    end
  end

`ifdef RECV_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; ready follows the freshly shifted-in bit
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      lfsr_q <= 16'hACE1 ^ 16'(ADDR);
      out_r  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      out_r  <= lfsr_d[0];
    end
  end
`else
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) out_r <= 1'b0;
    else        out_r <= 1'b1;
  end
`endif

  // Simulation-only trace of each completed packet
  generate
    if (DEBUG != 0) begin : g_debug
      always_ff @(posedge clk) begin
        if (a_rst && xfer && fl_tail)
          $display("pack_receiver: addr=%0d len=%0d status=%s",
                   fl_addr, 32'(len_q) + 32'd1, pkt_bad ? "bad" : "good");
      end
    end
  endgenerate

endmodule
